// File: rtl/fft_sequencer.sv
// fft_sequencer: address/control sequencer for a radix-2 in-place FFT with ping-pong banks.
// Latency: load writes appear 1 cycle after sampling; butterfly writes trail their reads by BF_LAT cycles.
// Backpressure: enable=0 freezes all state and forces rd_en/wr_en low; loads outside IDLE are ignored.
//
// Ports: clk/reset (async active-low), enable, go, mem0_load/mem1_load in;
//        rd_* (butterfly read), tw_idx, wr_* (load or write-back), stage, busy, done, res_bank out.
// Build option: define FFT_BITREV_LOAD_EN to bit-reverse load addresses (natural-order input).
module fft_sequencer #(
  parameter int N      = 8,
  parameter int BF_LAT = 2,
  localparam int AW    = $clog2(N),
  localparam int S     = AW,
  localparam int TW_W  = AW - 1,
  localparam int SW    = (S > 2) ? $clog2(S) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            go,
  input  logic            mem0_load,
  input  logic            mem1_load,
  output logic            rd_en,
  output logic            rd_bank,
  output logic [AW-1:0]   rd_addr_a,
  output logic [AW-1:0]   rd_addr_b,
  output logic [TW_W-1:0] tw_idx,
  output logic            wr_en,
  output logic            wr_bank,
  output logic [AW-1:0]   wr_addr_a,
  output logic [AW-1:0]   wr_addr_b,
  output logic [SW-1:0]   stage,
  output logic            busy,
  output logic            done,
  output logic            res_bank
);

  localparam int HALF      = N / 2;
  localparam int STAGE_LEN = HALF + BF_LAT;      // issue slots plus drain slots
  localparam int CW        = $clog2(STAGE_LEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // One in-flight butterfly on its way to write-back.
  typedef struct packed {
    logic          vld;
    logic          bank;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } wb_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [SW-1:0] s;
  logic [AW-1:0] k;
  wb_t           pipe [BF_LAT];

  logic            load_any, last_stage, issue, stage_end, run_end;
  logic [AW-1:0]   b_ext, span_mask, pos, grp, bf_a, bf_b;
  logic [TW_W-1:0] bf_tw;

  logic            rd_en_d, rd_bank_d, wr_en_d, wr_bank_d, busy_d, done_d;
  logic [AW-1:0]   rd_addr_a_d, rd_addr_b_d, wr_addr_a_d, wr_addr_b_d;
  logic [TW_W-1:0] tw_idx_d;

  assign res_bank = 1'(S % 2);
  assign stage    = s;

  function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] x);
`ifdef FFT_BITREV_LOAD_EN
    for (int i = 0; i < AW; i++) map_addr[i] = x[AW-1-i];
`else
    map_addr = x;
`endif
  endfunction

  assign load_any   = mem0_load | mem1_load;
  assign last_stage = (s == SW'(S - 1));
  assign issue      = (state == RUN) && (cnt < CW'(HALF));
  assign stage_end  = (cnt == CW'(STAGE_LEN - 1)) && !last_stage;
  // The final stage runs one slot longer so DONE is entered after its last write lands.
  assign run_end    = last_stage && (cnt == CW'(STAGE_LEN));

  // Butterfly addressing: rd_addr_a = (b div span)*2*span + pos, span = 2^s.
  always_comb begin
    b_ext     = {1'b0, cnt[AW-2:0]};
    span_mask = (AW'(1) << s) - AW'(1);
    pos       = b_ext & span_mask;
    grp       = b_ext >> s;
    bf_a      = (grp << (int'(s) + 1)) | pos;
    bf_b      = bf_a | (AW'(1) << s);
    bf_tw     = TW_W'(pos << (S - 1 - int'(s)));
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      state <= IDLE;
    else if (enable) state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go && !load_any) state_nxt = RUN;
      RUN:     if (run_end)         state_nxt = DONE;
      DONE:    if (!go)             state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // FSM: output next-values (registered below)
  always_comb begin
    rd_en_d     = 1'b0;
    rd_bank_d   = rd_bank;
    rd_addr_a_d = rd_addr_a;
    rd_addr_b_d = rd_addr_b;
    tw_idx_d    = tw_idx;
    wr_en_d     = 1'b0;
    wr_bank_d   = wr_bank;
    wr_addr_a_d = wr_addr_a;
    wr_addr_b_d = wr_addr_b;
    busy_d      = busy;
    done_d      = done;
    if (enable) begin
      busy_d = (state_nxt == RUN);
      done_d = (state_nxt == DONE);
      if (state == IDLE && load_any) begin
        wr_en_d     = 1'b1;
        wr_bank_d   = !mem0_load;          // mem0 wins when both are high
        wr_addr_a_d = map_addr(k);
        wr_addr_b_d = map_addr(k | AW'(1)); // k is always even
      end else if (pipe[BF_LAT-1].vld) begin
        wr_en_d     = 1'b1;
        wr_bank_d   = pipe[BF_LAT-1].bank;
        wr_addr_a_d = pipe[BF_LAT-1].a;
        wr_addr_b_d = pipe[BF_LAT-1].b;
      end
      if (issue) begin
        rd_en_d     = 1'b1;
        rd_bank_d   = s[0];
        rd_addr_a_d = bf_a;
        rd_addr_b_d = bf_b;
        tw_idx_d    = bf_tw;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_en     <= 1'b0;
      rd_bank   <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_idx    <= '0;
      wr_en     <= 1'b0;
      wr_bank   <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_en     <= rd_en_d;
      rd_bank   <= rd_bank_d;
      rd_addr_a <= rd_addr_a_d;
      rd_addr_b <= rd_addr_b_d;
      tw_idx    <= tw_idx_d;
      wr_en     <= wr_en_d;
      wr_bank   <= wr_bank_d;
      wr_addr_a <= wr_addr_a_d;
      wr_addr_b <= wr_addr_b_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Counters: load index k, stage s, slot cnt within a stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k   <= '0;
      s   <= '0;
      cnt <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          s   <= '0;
          cnt <= '0;
          k   <= load_any ? k + AW'(2) : '0;
        end
        RUN: begin
          if (stage_end) begin
            cnt <= '0;
            s   <= s + SW'(1);
          end else if (!run_end) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Write-back delay line; pipe[0] is loaded alongside the read outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BF_LAT; i++) pipe[i] <= '0;
    end else if (enable) begin
      pipe[0] <= '{vld: issue, bank: ~s[0], a: bf_a, b: bf_b};
      for (int i = 1; i < BF_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

endmodule

// File: tb/tb_fft_sequencer.sv
module tb_fft_sequencer;

  logic       clk = 1'b0;
  logic       reset, enable, go, mem0_load, mem1_load;
  logic       rd_en, rd_bank, wr_en, wr_bank, busy, done, res_bank;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_idx, stage;

  int n_cmp = 0;
  int n_bad = 0;

  // Hand-computed N=8 butterfly schedule: stage-major, 4 butterflies per stage.
  int ra [12] = '{0,2,4,6, 0,1,4,5, 0,1,2,3};
  int rb [12] = '{1,3,5,7, 2,3,6,7, 4,5,6,7};
  int tw [12] = '{0,0,0,0, 0,2,0,2, 0,1,2,3};
`ifdef FFT_BITREV_LOAD_EN
  int la [4] = '{0,2,1,3};
  int lb [4] = '{4,6,5,7};
`else
  int la [4] = '{0,2,4,6};
  int lb [4] = '{1,3,5,7};
`endif

  fft_sequencer #(.N(8), .BF_LAT(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .go(go),
    .mem0_load(mem0_load), .mem1_load(mem1_load),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_idx(tw_idx), .wr_en(wr_en), .wr_bank(wr_bank),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .stage(stage), .busy(busy), .done(done), .res_bank(res_bank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected outputs after edge e of an unstalled run (go sampled at edge 0).
  task automatic chk_run(input int e);
    int st, c, w, wst, wc;
    logic rv, wv;
    st = (e - 1) / 6;
    c  = (e - 1) % 6;
    rv = (st < 3) && (c < 4);
    chk($sformatf("rd_en@%0d", e), rd_en, rv);
    if (rv) begin
      chk($sformatf("rd_a@%0d", e), rd_addr_a, ra[st*4+c]);
      chk($sformatf("rd_b@%0d", e), rd_addr_b, rb[st*4+c]);
      chk($sformatf("tw@%0d", e), tw_idx, tw[st*4+c]);
      chk($sformatf("rd_bank@%0d", e), rd_bank, st % 2);
      chk($sformatf("stage@%0d", e), stage, st);
    end
    w  = e - 2;
    wv = 1'b0;
    wst = 0;
    wc = 0;
    if (w >= 1) begin
      wst = (w - 1) / 6;
      wc  = (w - 1) % 6;
      wv  = (wst < 3) && (wc < 4);
    end
    chk($sformatf("wr_en@%0d", e), wr_en, wv);
    if (wv) begin
      chk($sformatf("wr_a@%0d", e), wr_addr_a, ra[wst*4+wc]);
      chk($sformatf("wr_b@%0d", e), wr_addr_b, rb[wst*4+wc]);
      chk($sformatf("wr_bank@%0d", e), wr_bank, 1 - (wst % 2));
    end
    chk($sformatf("busy@%0d", e), busy, e < 19);
    chk($sformatf("done@%0d", e), done, e == 19);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_rd_a"}, rd_addr_a, 0);
    chk({tag, "_rd_b"}, rd_addr_b, 0);
    chk({tag, "_wr_a"}, wr_addr_a, 0);
    chk({tag, "_wr_b"}, wr_addr_b, 0);
    chk({tag, "_banks"}, {rd_bank, wr_bank}, 0);
    chk({tag, "_tw"}, tw_idx, 0);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_res_bank"}, res_bank, 1);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; go = 1'b0; mem0_load = 1'b0; mem1_load = 1'b0;
    #3;
    chk_zero("reset");
    #10 reset = 1'b1;
    tick; tick;

    // Loads into bank 0: four two-sample writes, k wraps back to 0.
    mem0_load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("ld0_wr_en%0d", i), wr_en, 1);
      chk($sformatf("ld0_bank%0d", i), wr_bank, 0);
      chk($sformatf("ld0_a%0d", i), wr_addr_a, la[i]);
      chk($sformatf("ld0_b%0d", i), wr_addr_b, lb[i]);
    end
    // mem1 only: bank 1, k restarted from the wrap.
    mem0_load = 1'b0; mem1_load = 1'b1;
    tick;
    chk("ld1_bank", wr_bank, 1);
    chk("ld1_a", wr_addr_a, la[0]);
    chk("ld1_b", wr_addr_b, lb[0]);
    // Both loads plus go: mem0 wins, go ignored.
    mem0_load = 1'b1; go = 1'b1;
    tick;
    chk("ldboth_bank", wr_bank, 0);
    chk("ldboth_a", wr_addr_a, la[1]);
    chk("ldboth_b", wr_addr_b, lb[1]);
    chk("ldboth_busy", busy, 0);
    mem0_load = 1'b0; mem1_load = 1'b0; go = 1'b0;
    tick;
    chk("ld_idle_wr_en", wr_en, 0);
    chk("ld_idle_busy", busy, 0);

    // Full run with go held high.
    go = 1'b1;
    tick;
    chk("run_e0_busy", busy, 1);
    chk("run_e0_rd_en", rd_en, 0);
    for (int e = 1; e <= 19; e++) begin
      tick;
      chk_run(e);
    end
    tick;
    chk("done_hold", done, 1);
    chk("done_hold_wr", wr_en, 0);
    go = 1'b0;
    tick;
    chk("done_drop", done, 0);
    chk("idle_busy", busy, 0);
    tick;

    // Stall: enable low on edges 8..10 (stage 1 reads).
    go = 1'b1;
    tick;
    for (int e = 1; e <= 22; e++) begin
      enable = !(e >= 8 && e <= 10);
      tick;
      if (e >= 8 && e <= 10) begin
        chk($sformatf("stall_rd_en@%0d", e), rd_en, 0);
        chk($sformatf("stall_wr_en@%0d", e), wr_en, 0);
        chk($sformatf("stall_rd_a@%0d", e), rd_addr_a, 0);
        chk($sformatf("stall_rd_b@%0d", e), rd_addr_b, 2);
        chk($sformatf("stall_stage@%0d", e), stage, 1);
        chk($sformatf("stall_busy@%0d", e), busy, 1);
        chk($sformatf("stall_done@%0d", e), done, 0);
      end else begin
        chk_run(e < 8 ? e : e - 3);
      end
    end
    enable = 1'b1;
    go = 1'b0;
    tick;
    chk("stall_done_drop", done, 0);
    tick;

    // Reset mid-run.
    go = 1'b1;
    for (int e = 0; e < 10; e++) tick;
    chk("pre_reset_busy", busy, 1);
    go = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk_zero("midreset");
    tick;
    #2 reset = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick;
      chk($sformatf("post_reset_wr_en%0d", e), wr_en, 0);
      chk($sformatf("post_reset_rd_en%0d", e), rd_en, 0);
      chk($sformatf("post_reset_busy%0d", e), busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

Control sequencer for the radix-2 in-place FFT datapath with ping-pong sample banks (mem0/mem1).
- Generates external-load write addresses, per-stage butterfly read/write addresses, bank selects and twiddle indices.
- Issues one butterfly per enabled cycle and signals completion with `done`.
- Sits between the top-level `go`/load controls and the two-bank memory plus butterfly unit inside `FFT`.

## Interface
- `N`, 8: transform length, power of two, ≥4.
- `BF_LAT`, 2: butterfly latency in cycles, read issue to write-back, ≥1.
- Derived: `AW` = log2(N); `S` = AW stages; `TW_W` = AW-1; `SW` = max(1, ceil(log2(S))).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `enable` input 1: advance qualifier; 0 freezes all state.
- `go` input 1: start request, level-sampled in IDLE.
- `mem0_load`, `mem1_load` input 1 each: external two-sample load into bank 0/1.
- `rd_en` output 1: butterfly read valid.
- `rd_bank` output 1: source bank.
- `rd_addr_a`, `rd_addr_b` output AW each: butterfly operand addresses.
- `tw_idx` output TW_W: twiddle ROM index.
- `wr_en` output 1: write valid (load or butterfly write-back).
- `wr_bank` output 1: destination bank.
- `wr_addr_a`, `wr_addr_b` output AW each: write addresses.
- `stage` output SW: current stage.
- `busy` output 1: high in RUN.
- `done` output 1: high in DONE.
- `res_bank` output 1: constant S mod 2, the bank holding the result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, load: `mem0_load`=1 drives `wr_en`=1, `wr_bank`=0. Otherwise `mem1_load`=1 drives `wr_bank`=1; mem0 wins if both are high.
- Load counter `k` advances by 2 per load cycle and wraps modulo N. `k` clears on any IDLE cycle with no load.
- Load write addresses: `wr_addr_a`=map(k), `wr_addr_b`=map(k+1). `map` is defined under Configuration.
- IDLE → RUN: on `go`=1 with no load active; `go` is ignored while a load is high.
- RUN: stage s = 0..S-1, butterfly b = 0..N/2-1.
- Per-butterfly terms: span = 2^s, pos = b mod span.
- `rd_addr_a` = (b div span)·2·span + pos; `rd_addr_b` = `rd_addr_a` + span.
- `tw_idx` = pos << (S-1-s).
- `rd_bank` = s mod 2.
- After b = N/2-1, hold `rd_en`=0 for BF_LAT drain cycles so every write of stage s lands before stage s+1 reads. Then s advances.
- Write-back: `wr_en`, `wr_addr_a/b` are the `rd_en`/`rd_addr` values delayed BF_LAT enabled cycles, with `wr_bank` = ¬(s mod 2) of the issuing stage.
- RUN → DONE: after the final write of stage S-1.
- DONE → IDLE: when `go`=0, so a held `go` does not retrigger.
- `enable`=0 freezes state, counters and the delay line. `rd_en` and `wr_en` are forced to 0; other outputs hold. Loads are ignored.
- Loads asserted during RUN or DONE are ignored.

## Timing
- Reset values: state IDLE, `k`=0, s=0, b=0, delay line cleared. All outputs 0 except `res_bank` (constant).
- Reset mid-operation: immediate abort to IDLE; no further writes.
- All outputs are registered.
- Load write appears one cycle after the load input is sampled.
- `go` sampled at edge 0 gives the first `rd_en` at cycle 1.
- Stage s reads at cycles 1+s·(N/2+BF_LAT) .. N/2+s·(N/2+BF_LAT).
- Writes occur BF_LAT cycles after the corresponding reads.
- `done` rises in the cycle after the last write.
- N=8, BF_LAT=2: 6 cycles per stage, last write at cycle 18, `done` at cycle 19.
- Each enable-low cycle adds exactly one cycle to this schedule.

## Configuration
- `FFT_BITREV_LOAD_EN` defined: map(x) = AW-bit bit-reverse of x. Natural-order input lands in bit-reversed order as the DIT schedule requires.
- Undefined: map(x) = x; the caller pre-orders the samples.
- RUN behaviour is identical in both builds.

## Test plan
- Reset: hold `reset`=0 mid-run → all outputs 0 except `res_bank`=1 (N=8); state IDLE; no `wr_en` after release until a new `go`.
- Load with `FFT_BITREV_LOAD_EN`: `mem0_load`=1 for 4 cycles → `wr_bank`=0, (a,b) = (0,4),(2,6),(1,5),(3,7).
- Load without `FFT_BITREV_LOAD_EN`: same stimulus → (0,1),(2,3),(4,5),(6,7).
- Run address schedule (N=8, BF_LAT=2), `go` held high:
  - stage 0: (0,1),(2,3),(4,5),(6,7), tw 0, `rd_bank`=0.
  - stage 1: (0,2)t0, (1,3)t2, (4,6)t0, (5,7)t2, `rd_bank`=1.
  - stage 2: (0,4)t0, (1,5)t1, (2,6)t2, (3,7)t3, `rd_bank`=0.
- Run completion and handshake: same run → each write mirrors its read 2 cycles later on the opposite bank; `done`=1 at cycle 19 and held while `go`=1; IDLE the cycle after `go` drops.
- Stall: `enable`=0 for 3 cycles during stage 1 → no rd/wr strobes in those cycles; `done` at cycle 22; addresses unchanged.
